// File: rtl/lcd_disp_pkg.sv
// Shared constants and state encoding for the LCD page arbitration logic.
package lcd_disp_pkg;

  localparam int LCD_CHARS   = 32;
  localparam int LCD_FRAME_W = 256;

  localparam logic [7:0]             CHAR_SPACE  = 8'h20;
  localparam logic [LCD_FRAME_W-1:0] BLANK_FRAME = {LCD_CHARS{CHAR_SPACE}};

  localparam logic [3:0] SRC_NONE = 4'hF;

  typedef enum logic {
    BG   = 1'b0,
    SHOW = 1'b1
  } disp_state_t;

endpackage

// File: rtl/lcd_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CLK_PER_MS clocks, restartable via clr.
module lcd_ms_tick #(
  parameter int CLK_PER_MS = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/lcd_page_arbiter.sv
// Picks the frame sent to the LCD1602 driver: background page or a timed,
// priority-arbitrated message with optional blink.
//
//   state | meaning
//   BG    | background page on dis_data, waiting for any request
//   SHOW  | latched message on dis_data, hold timer running
module lcd_page_arbiter
  import lcd_disp_pkg::*;
#(
  parameter int NUM_MSG    = 4,
  parameter int CLK_PER_MS = 50_000,
  parameter int HOLD_MS    = 3000,
  parameter int BLINK_MS   = 500
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [LCD_FRAME_W-1:0]         bg_frame,
  input  logic [NUM_MSG-1:0]             msg_req,
  input  logic [NUM_MSG*LCD_FRAME_W-1:0] msg_frame,
  input  logic [NUM_MSG-1:0]             msg_blink,
  input  logic                           msg_clear,
  output logic [NUM_MSG-1:0]             msg_ack,
  output logic [NUM_MSG-1:0]             msg_done,
  output logic                           busy,
  output logic [3:0]                     active_src,
  output logic [LCD_FRAME_W-1:0]         dis_data
);

  localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam int CNT_W = $clog2(HOLD_MS + 1);

  disp_state_t state, state_d;

  logic [LCD_FRAME_W-1:0] frame_q, frame_d;
  logic                   blink_en_q, blink_en_d;
  logic                   phase_q, phase_d;
  logic [CNT_W-1:0]       hold_cnt, hold_d;
  logic [CNT_W-1:0]       blink_cnt, blink_cnt_d;
  logic [IDX_W-1:0]       cur_idx, cur_d;

  logic [NUM_MSG-1:0]     ack_d, done_d;
  logic                   busy_d;
  logic [3:0]             src_d;
  logic [LCD_FRAME_W-1:0] dis_d;

  logic                   req_any;
  logic [IDX_W-1:0]       req_idx;
  logic [LCD_FRAME_W-1:0] req_frame;
  logic                   req_blink;
  logic                   grant;
  logic                   expire;
  logic                   tick;
  logic                   tick_clr;

  // Lowest index wins: scan from the top so the last hit is the highest priority.
  always_comb begin
    req_any   = 1'b0;
    req_idx   = '0;
    req_frame = BLANK_FRAME;
    req_blink = 1'b0;
    for (int i = NUM_MSG - 1; i >= 0; i--) begin
      if (msg_req[i]) begin
        req_any   = 1'b1;
        req_idx   = IDX_W'(i);
        req_frame = msg_frame[i*LCD_FRAME_W +: LCD_FRAME_W];
        req_blink = msg_blink[i];
      end
    end
  end

  // A clear in SHOW outranks any request; requests at or above the current priority re-grant.
  always_comb begin
    grant = 1'b0;
    if (state == BG) begin
      grant = req_any;
    end else if (!msg_clear && req_any && (req_idx <= cur_idx)) begin
      grant = 1'b1;
    end
  end

  assign expire   = tick && (hold_cnt == CNT_W'(HOLD_MS - 1));
  assign tick_clr = (state == BG) || grant;

  lcd_ms_tick #(
    .CLK_PER_MS (CLK_PER_MS)
  ) u_ms_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_comb begin
    state_d     = state;
    frame_d     = frame_q;
    blink_en_d  = blink_en_q;
    phase_d     = phase_q;
    hold_d      = hold_cnt;
    blink_cnt_d = blink_cnt;
    cur_d       = cur_idx;
    ack_d       = '0;
    done_d      = '0;
    busy_d      = busy;
    src_d       = active_src;
    dis_d       = dis_data;

    if (grant) begin
      state_d        = SHOW;
      frame_d        = req_frame;
      blink_en_d     = req_blink;
      phase_d        = 1'b1;
      hold_d         = '0;
      blink_cnt_d    = '0;
      cur_d          = req_idx;
      ack_d[req_idx] = 1'b1;
      busy_d         = 1'b1;
      src_d          = 4'(req_idx);
      dis_d          = req_frame;
    end else begin
      case (state)
        BG: begin
          busy_d = 1'b0;
          src_d  = SRC_NONE;
          dis_d  = bg_frame;
        end
        SHOW: begin
          if (msg_clear || expire) begin
            if (!msg_clear) begin
              done_d[cur_idx] = 1'b1;
            end
            state_d = BG;
            busy_d  = 1'b0;
            src_d   = SRC_NONE;
            dis_d   = bg_frame;
          end else begin
            if (tick) begin
              hold_d = hold_cnt + CNT_W'(1);
              if (blink_cnt == CNT_W'(BLINK_MS - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
              end else begin
                blink_cnt_d = blink_cnt + CNT_W'(1);
              end
            end
            dis_d = (blink_en_q && !phase_d) ? BLANK_FRAME : frame_q;
          end
        end
        default: begin
          state_d = BG;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BG;
      frame_q    <= BLANK_FRAME;
      blink_en_q <= 1'b0;
      phase_q    <= 1'b1;
      hold_cnt   <= '0;
      blink_cnt  <= '0;
      cur_idx    <= '0;
      msg_ack    <= '0;
      msg_done   <= '0;
      busy       <= 1'b0;
      active_src <= SRC_NONE;
      dis_data   <= BLANK_FRAME;
    end else begin
      state      <= state_d;
      frame_q    <= frame_d;
      blink_en_q <= blink_en_d;
      phase_q    <= phase_d;
      hold_cnt   <= hold_d;
      blink_cnt  <= blink_cnt_d;
      cur_idx    <= cur_d;
      msg_ack    <= ack_d;
      msg_done   <= done_d;
      busy       <= busy_d;
      active_src <= src_d;
      dis_data   <= dis_d;
    end
  end

endmodule
